// File: rtl/prefetch_unit_pkg.sv
// prefetch_unit_pkg: shared types, constants and fetch helper for the prefetch unit
package prefetch_unit_pkg;
  typedef enum logic [1:0] {RUN, WAIT, DISCARD} fetch_state_t;
  typedef enum logic {MODE_ARM, MODE_THUMB} fetch_mode_t;
  localparam int PC_STEP_ARM = 4;
  localparam int PC_STEP_THUMB = 2;
  localparam int PC_W = 32;
  typedef struct packed {
    logic [31:0] instr;
    logic [PC_W-1:0] pc;
    fetch_mode_t mode;
  } fetch_entry_t;
  function automatic logic [31:0] fetch_instr(fetch_mode_t m, logic a1, logic [31:0] d);
    return m == MODE_THUMB ? {16'h0, a1 ? d[31:16] : d[15:0]} : d;
  endfunction
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: generic DEPTH-entry synchronous FIFO with single-cycle clear
//   clk, reset (async, active-low), clr, push/din, pop, head (entry at read pointer), count
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  T                           din,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [AW-1:0] rd, wr;
  assign head = mem[rd];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr] <= din;
      wr <= wr + AW'(push);
      rd <= rd + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: ARM7 instruction prefetch queue between the bus master port and the decoder
//   memory side : mem_req/mem_addr out, mem_ready/mem_rdata in (one outstanding request)
//   control     : flush/flush_pc/thumb restart the stream; reset is async active-low
//   decoder side: ir_valid/ir/ir_pc out, ir_ready in; level = occupied entries
//   PREFETCH_BYPASS_EN: an empty queue forwards returning data to ir in the same cycle
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic                       mem_ready,
  input  logic [31:0]                mem_rdata,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          flush_pc,
  input  logic                       thumb,
  output logic                       ir_valid,
  output logic [31:0]                ir,
  output logic [ADDR_W-1:0]          ir_pc,
  input  logic                       ir_ready,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  fetch_state_t state;
  fetch_mode_t mode_q;
  logic [ADDR_W-1:0] fetch_pc;
  fetch_entry_t din, head;
  logic q_valid, pop, take, push, byp, space;
  assign q_valid = level != '0;
  assign pop = q_valid & ir_ready & ~flush;
  assign take = state == WAIT & mem_ready & ~flush;
  assign space = (int'(level) - int'(pop)) < DEPTH;
  assign din = '{instr: fetch_instr(mode_q, mem_addr[1], mem_rdata), pc: PC_W'(mem_addr), mode: mode_q};
`ifdef PREFETCH_BYPASS_EN
  assign byp = take & ~q_valid;
`else
  assign byp = 1'b0;
`endif
  // a bypassed instruction that the decoder takes immediately never enters the queue
  assign push = take & ~(byp & ir_ready);
  always_comb begin
    ir_valid = q_valid | byp;
    ir = byp ? din.instr : head.mode == MODE_THUMB ? {16'h0, head.instr[15:0]} : head.instr;
    ir_pc = byp ? mem_addr : ADDR_W'(head.pc);
  end
  prefetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
    .clk(clk), .reset(reset), .clr(flush), .push(push), .pop(pop),
    .din(din), .head(head), .count(level)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      mode_q <= MODE_ARM;
      fetch_pc <= RESET_PC;
      mem_req <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      if (flush) begin
        fetch_pc <= {flush_pc[ADDR_W-1:2], flush_pc[1] & thumb, 1'b0};
        mode_q <= thumb ? MODE_THUMB : MODE_ARM;
      end else if (take)
        fetch_pc <= fetch_pc + ADDR_W'(mode_q == MODE_THUMB ? PC_STEP_THUMB : PC_STEP_ARM);
      case (state)
        RUN:
          if (!flush && space) begin
            state <= WAIT;
            mem_req <= 1'b1;
            mem_addr <= fetch_pc;
          end
        WAIT, DISCARD:
          if (mem_ready) begin
            state <= RUN;
            mem_req <= 1'b0;
          end else if (flush)
            state <= DISCARD;
        default: state <= RUN;
      endcase
    end
endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit: directed vectors with hand-computed expectations for prefetch_unit
module tb_prefetch_unit;
  logic clk = 1'b0, reset = 1'b0;
  logic mem_req, mem_ready = 1'b0, flush = 1'b0, thumb = 1'b0, ir_valid, ir_ready = 1'b0;
  logic [31:0] mem_addr, flush_pc = '0, ir, ir_pc, mem_rdata, fixed = '0;
  logic [2:0] level;
  logic use_fixed = 1'b0;
  int vec = 0, errs = 0, n_req;
  logic [31:0] addrs [$];
  always #5 clk = ~clk;
  assign mem_rdata = use_fixed ? fixed : 32'hE000_0000 | mem_addr;
  prefetch_unit dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .flush(flush), .flush_pc(flush_pc), .thumb(thumb),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready), .level(level)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", 32'(mem_req), 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", 32'(ir_valid), 0);
    check("rst_ir", ir, 0);
    check("rst_irpc", ir_pc, 0);
    check("rst_level", 32'(level), 0);
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_req) addrs.push_back(mem_addr);
    end
    check("fill_nreq", 32'(addrs.size()), 4);
    for (int i = 0; i < 4 && i < addrs.size(); i++) check("fill_addr", addrs[i], 32'(4 * i));
    check("fill_level", 32'(level), 4);
    check("fill_req", 32'(mem_req), 0);
    check("fill_ir", ir, 32'hE000_0000);
    check("fill_irpc", ir_pc, 0);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("pop_level", 32'(level), 3);
    check("pop_req", 32'(mem_req), 1);
    check("pop_addr", mem_addr, 32'h10);
    check("pop_irpc", ir_pc, 32'h4);
    n_req = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_req += int'(mem_req);
    end
    check("pop_nreq", 32'(n_req), 1);
    check("pop_refill", 32'(level), 4);
    mem_ready = 1'b0;
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("wait_addr", mem_addr, 32'h14);
    flush = 1'b1;
    flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    check("disc_level", 32'(level), 0);
    repeat (2) tick();
    check("disc_req", 32'(mem_req), 1);
    check("disc_addr", mem_addr, 32'h14);
    check("disc_level2", 32'(level), 0);
    mem_ready = 1'b1;
    #1 check("disc_nobyp", 32'(ir_valid), 0);
    tick();
    check("drop_level", 32'(level), 0);
    check("drop_req", 32'(mem_req), 0);
    tick();
    check("refetch_addr", mem_addr, 32'h100);
    check("refetch_req", 32'(mem_req), 1);
    tick();
    check("refetch_level", 32'(level), 1);
    check("refetch_irpc", ir_pc, 32'h100);
    check("refetch_ir", ir, 32'hE000_0100);
    flush = 1'b1;
    thumb = 1'b1;
    flush_pc = 32'h203;
    use_fixed = 1'b1;
    fixed = 32'hAAAA_5555;
    tick();
    flush = 1'b0;
    thumb = 1'b0;
    check("th_flush_level", 32'(level), 0);
    tick();
    check("th_addr0", mem_addr, 32'h202);
    tick();
    check("th_ir0", ir, 32'h0000_AAAA);
    check("th_irpc0", ir_pc, 32'h202);
    tick();
    check("th_addr1", mem_addr, 32'h204);
    tick();
    check("th_level", 32'(level), 2);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    check("th_ir1", ir, 32'h0000_5555);
    check("th_irpc1", ir_pc, 32'h204);
    check("th_addr2", mem_addr, 32'h206);
    flush = 1'b1;
    flush_pc = 32'h300;
    ir_ready = 1'b1;
    tick();
    flush = 1'b0;
    ir_ready = 1'b0;
    mem_ready = 1'b0;
    check("fl3_level", 32'(level), 0);
    check("fl3_valid", 32'(ir_valid), 0);
    check("fl3_req", 32'(mem_req), 0);
    tick();
    check("fl3_addr", mem_addr, 32'h300);
    check("fl3_valid2", 32'(ir_valid), 0);
    fixed = 32'hE3A0_0001;
    mem_ready = 1'b1;
    #1;
`ifdef PREFETCH_BYPASS_EN
    check("byp_valid", 32'(ir_valid), 1);
    check("byp_ir", ir, 32'hE3A0_0001);
    check("byp_irpc", ir_pc, 32'h300);
`else
    check("nobyp_valid", 32'(ir_valid), 0);
`endif
    tick();
    mem_ready = 1'b0;
    check("lat_valid", 32'(ir_valid), 1);
    check("lat_ir", ir, 32'hE3A0_0001);
    check("lat_level", 32'(level), 1);
    tick();
    check("mid_req", 32'(mem_req), 1);
    check("mid_addr", mem_addr, 32'h304);
    reset = 1'b0;
    #1;
    check("arst_req", 32'(mem_req), 0);
    check("arst_addr", mem_addr, 0);
    check("arst_level", 32'(level), 0);
    check("arst_valid", 32'(ir_valid), 0);
    mem_ready = 1'b1;
    tick();
    check("arst_ign_req", 32'(mem_req), 0);
    check("arst_ign_level", 32'(level), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
